uart_tx_gen: RTL and testbench

Parametrised UART transmitter, the successor of the fixed-format 5–8-bit transmitter. It pulls words from a FIFO with a first-word-fall-through interface and serialises them onto `uartTxLine`, paced by an oversampled baud tick. Over its predecessor it adds:
- data widths up to `MAX_DATA_BITS`;
- a configurable tick-per-bit ratio and 1, 1.5 or 2 stop bits;
- mark and space parity;
- CTS flow control and a break generator;
- back-to-back frames with no idle gap, and a frame-done pulse.

---
 rtl/uart_tx_gen_if.sv | 11 +
 rtl/uart_tx_gen.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_gen_if.sv
// FIFO read port of the UART transmitter: first-word-fall-through data/empty plus a pop strobe.
interface uart_tx_gen_if #(
    parameter int unsigned MAX_DATA_BITS = 9
) ();
    logic [MAX_DATA_BITS-1:0] fifoData;
    logic                     fifoEmpty;
    logic                     fifoReadAck;

    modport master (input fifoData, input fifoEmpty, output fifoReadAck);
    modport slave  (output fifoData, output fifoEmpty, input fifoReadAck);
endinterface

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter: FWFT FIFO source, configurable word/parity/stop format,
// CTS flow control, break generation and back-to-back frames.
module uart_tx_gen #(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned TICKS_PER_BIT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          baudTick,
    input  logic [3:0]    dataBits,
    input  logic [2:0]    parityMode,
    input  logic [1:0]    stopBits,
    input  logic          ctsEnable,
    input  logic          ctsN,
    input  logic          breakReq,
    uart_tx_gen_if.master fifo,
    output logic          busy,
    output logic          frameDone,
    output logic          uartTxLine
);
    localparam int unsigned TICK_W = $clog2(2 * TICKS_PER_BIT);
    localparam logic [TICK_W-1:0] BIT_LAST    = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] STOP15_LAST = TICK_W'((3 * TICKS_PER_BIT) / 2 - 1);
    localparam logic [TICK_W-1:0] STOP2_LAST  = TICK_W'(2 * TICKS_PER_BIT - 1);
    localparam logic [3:0]        MIN_BITS    = 4'd5;
    localparam logic [3:0]        MAX_BITS    = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP, BREAK, MARK} txState_t;

    txState_t                 state, stateNext;
    logic [TICK_W-1:0]        tickCnt, tickNext;
    logic [3:0]               bitCnt, bitNext;
    logic [MAX_DATA_BITS-1:0] shiftReg, shiftNext;
    logic [3:0]               lastBitIdx, lastBitNext;
    logic                     parEn, parEnNext;
    logic                     parBit, parBitNext;
    logic [TICK_W-1:0]        stopLast, stopLastNext;
    logic                     readAckQ, readAckNext;
    logic                     lineNext, doneNext;
    logic                     loadWord, bitEnd, go;
    logic [3:0]               nEff;
    logic                     wordParity;

    assign go = !fifo.fifoEmpty && !breakReq && (!ctsEnable || !ctsN);
    assign fifo.fifoReadAck = readAckQ;

    // Clamp the requested word length and fold parity over the bits that will be sent.
    always_comb begin
        nEff = dataBits;
        if (dataBits < MIN_BITS)      nEff = MIN_BITS;
        else if (dataBits > MAX_BITS) nEff = MAX_BITS;
        wordParity = 1'b0;
        for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
            if (4'(i) < nEff) wordParity = wordParity ^ fifo.fifoData[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tickCnt    <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            lastBitIdx <= '0;
            parEn      <= 1'b0;
            parBit     <= 1'b0;
            stopLast   <= '0;
            readAckQ   <= 1'b0;
            frameDone  <= 1'b0;
            busy       <= 1'b0;
            uartTxLine <= 1'b1;
        end else begin
            state      <= stateNext;
            tickCnt    <= tickNext;
            bitCnt     <= bitNext;
            shiftReg   <= shiftNext;
            lastBitIdx <= lastBitNext;
            parEn      <= parEnNext;
            parBit     <= parBitNext;
            stopLast   <= stopLastNext;
            readAckQ   <= readAckNext;
            frameDone  <= doneNext;
            busy       <= (stateNext != IDLE);
            uartTxLine <= lineNext;
        end
    end

    always_comb begin
        stateNext    = state;
        tickNext     = tickCnt;
        bitNext      = bitCnt;
        shiftNext    = shiftReg;
        lastBitNext  = lastBitIdx;
        parEnNext    = parEn;
        parBitNext   = parBit;
        stopLastNext = stopLast;
        lineNext     = uartTxLine;
        readAckNext  = 1'b0;
        doneNext     = 1'b0;
        loadWord     = 1'b0;
        bitEnd       = baudTick && (tickCnt == BIT_LAST);

        unique case (state)
            IDLE: begin
                if (breakReq) begin
                    stateNext = BREAK;
                    lineNext  = 1'b0;
                end else if (go) begin
                    stateNext = LOAD;
                end
            end
            LOAD: loadWord = baudTick;
            START: begin
                if (baudTick) tickNext = tickCnt + TICK_W'(1);
                if (bitEnd) begin
                    tickNext  = '0;
                    bitNext   = '0;
                    stateNext = DATA;
                    lineNext  = shiftReg[0];
                end
            end
            DATA: begin
                if (baudTick) tickNext = tickCnt + TICK_W'(1);
                if (bitEnd) begin
                    tickNext = '0;
                    if (bitCnt == lastBitIdx) begin
                        stateNext = parEn ? PARITY : STOP;
                        lineNext  = parEn ? parBit : 1'b1;
                    end else begin
                        bitNext   = bitCnt + 4'd1;
                        shiftNext = shiftReg >> 1;
                        lineNext  = shiftReg[1];
                    end
                end
            end
            PARITY: begin
                if (baudTick) tickNext = tickCnt + TICK_W'(1);
                if (bitEnd) begin
                    tickNext  = '0;
                    stateNext = STOP;
                    lineNext  = 1'b1;
                end
            end
            // Frame end: CTS and break are only looked at here and in IDLE.
            STOP: begin
                if (baudTick) begin
                    tickNext = tickCnt + TICK_W'(1);
                    if (tickCnt == stopLast) begin
                        tickNext = '0;
                        doneNext = 1'b1;
                        if (go) begin
                            loadWord = 1'b1;
                        end else if (breakReq) begin
                            stateNext = BREAK;
                            lineNext  = 1'b0;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
            end
            BREAK: begin
                if (!breakReq) begin
                    stateNext = MARK;
                    lineNext  = 1'b1;
                    tickNext  = '0;
                end
            end
            MARK: begin
                if (baudTick) tickNext = tickCnt + TICK_W'(1);
                if (bitEnd) begin
                    tickNext  = '0;
                    stateNext = IDLE;
                end
            end
        endcase

        // Shared by LOAD and the back-to-back path out of STOP.
        if (loadWord) begin
            stateNext    = START;
            lineNext     = 1'b0;
            tickNext     = '0;
            readAckNext  = 1'b1;
            shiftNext    = fifo.fifoData;
            lastBitNext  = nEff - 4'd1;
            parEnNext    = (parityMode != 3'd0) && (parityMode <= 3'd4);
            case (parityMode)
                3'd1:    parBitNext = ~wordParity;
                3'd2:    parBitNext = wordParity;
                3'd3:    parBitNext = 1'b1;
                default: parBitNext = 1'b0;
            endcase
            case (stopBits)
                2'd0:    stopLastNext = BIT_LAST;
                2'd1:    stopLastNext = STOP15_LAST;
                default: stopLastNext = STOP2_LAST;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: table of frame formats plus back-to-back, CTS/break and reset sequences.
module tb_uart_tx_gen;
    localparam int TPB = 2;

    typedef struct {
        logic [8:0]  word;
        logic [3:0]  nBits;
        logic [2:0]  par;
        logic [1:0]  stop;
        logic [15:0] seq;
        int          bits;
        int          stopTicks;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       baudTick;
    logic [3:0] dataBits;
    logic [2:0] parityMode;
    logic [1:0] stopBits;
    logic       ctsEnable, ctsN, breakReq;
    logic       busy, frameDone, uartTxLine;

    logic lineS, ackS, doneS, busyS;
    int   total = 0;
    int   bad   = 0;
    int   ackCnt = 0;
    int   doneCnt = 0;
    vec_t vecs [8];

    uart_tx_gen_if #(.MAX_DATA_BITS(9)) fifoIf ();

    uart_tx_gen #(.MAX_DATA_BITS(9), .TICKS_PER_BIT(TPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .baudTick   (baudTick),
        .dataBits   (dataBits),
        .parityMode (parityMode),
        .stopBits   (stopBits),
        .ctsEnable  (ctsEnable),
        .ctsN       (ctsN),
        .breakReq   (breakReq),
        .fifo       (fifoIf.master),
        .busy       (busy),
        .frameDone  (frameDone),
        .uartTxLine (uartTxLine)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (fifoIf.fifoReadAck) ackCnt <= ackCnt + 1;
        if (frameDone)          doneCnt <= doneCnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One baud tick followed by two quiet cycles; outputs sampled right after the tick edge.
    task automatic stepTick();
        baudTick = 1'b1;
        @(posedge clock); #1;
        baudTick = 1'b0;
        lineS = uartTxLine;
        ackS  = fifoIf.fifoReadAck;
        doneS = frameDone;
        busyS = busy;
        @(posedge clock); #1;
        @(posedge clock); #1;
    endtask

    task automatic startFrame(input logic [8:0] w, input logic [3:0] n, input logic [2:0] p,
                              input logic [1:0] s, input string nm);
        dataBits = n; parityMode = p; stopBits = s;
        fifoIf.fifoData = w; fifoIf.fifoEmpty = 1'b0;
        @(posedge clock); #1;
        check({nm, "_busy_load"}, busy, 1'b1);
        check({nm, "_line_load"}, uartTxLine, 1'b1);
        stepTick();
        check({nm, "_start"}, lineS, 1'b0);
        check({nm, "_pop"}, ackS, 1'b1);
    endtask

    // Ticks 1..F-1 of a frame whose load tick has already happened.
    task automatic playBits(input logic [15:0] seq, input int bits, input int stopTicks,
                            input int breakAt, input string nm);
        int   f;
        int   k;
        logic expLine;
        logic earlyDone;
        f = TPB * bits + stopTicks;
        earlyDone = 1'b0;
        for (int j = 1; j < f; j++) begin
            if (j == breakAt) breakReq = 1'b1;
            stepTick();
            k = j / TPB;
            if (k < bits) expLine = seq[k];
            else          expLine = 1'b1;
            check($sformatf("%s_t%0d", nm, j), lineS, expLine);
            earlyDone = earlyDone | doneS | ackS;
        end
        check({nm, "_early_done_or_pop"}, earlyDone, 1'b0);
    endtask

    initial begin
        int a0;
        int d0;
        vecs[0] = '{9'h055, 4'd8,  3'd0, 2'd0, 16'h00AA, 9,  2};
        vecs[1] = '{9'h1FF, 4'd9,  3'd2, 2'd2, 16'h07FE, 11, 4};
        vecs[2] = '{9'h0FF, 4'd9,  3'd2, 2'd2, 16'h01FE, 11, 4};
        vecs[3] = '{9'h013, 4'd5,  3'd1, 2'd1, 16'h0026, 7,  3};
        vecs[4] = '{9'h180, 4'd7,  3'd3, 2'd0, 16'h0100, 9,  2};
        vecs[5] = '{9'h1FF, 4'd2,  3'd4, 2'd0, 16'h003E, 7,  2};
        vecs[6] = '{9'h12D, 4'd15, 3'd7, 2'd3, 16'h025A, 10, 4};
        vecs[7] = '{9'h003, 4'd6,  3'd1, 2'd0, 16'h0086, 8,  2};

        reset = 1'b0; baudTick = 1'b0; dataBits = 4'd8; parityMode = 3'd0; stopBits = 2'd0;
        ctsEnable = 1'b0; ctsN = 1'b0; breakReq = 1'b0;
        fifoIf.fifoData = '0; fifoIf.fifoEmpty = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_line", uartTxLine, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pop", fifoIf.fifoReadAck, 1'b0);
        check("rst_done", frameDone, 1'b0);
        reset = 1'b1;
        stepTick();
        check("idle_busy", busyS, 1'b0);

        // Table of frame formats; config inputs are scrambled after the load to prove shadowing.
        for (int v = 0; v < 8; v++) begin
            a0 = ackCnt; d0 = doneCnt;
            startFrame(vecs[v].word, vecs[v].nBits, vecs[v].par, vecs[v].stop, $sformatf("vec%0d", v));
            fifoIf.fifoEmpty = 1'b1;
            fifoIf.fifoData  = ~vecs[v].word;
            dataBits   = (vecs[v].nBits > 4'd6) ? 4'd5 : 4'd9;
            parityMode = (vecs[v].par == 3'd0) ? 3'd2 : 3'd0;
            stopBits   = (vecs[v].stop == 2'd0) ? 2'd2 : 2'd0;
            playBits(vecs[v].seq, vecs[v].bits, vecs[v].stopTicks, 0, $sformatf("vec%0d", v));
            stepTick();
            check($sformatf("vec%0d_done", v), doneS, 1'b1);
            check($sformatf("vec%0d_line_end", v), lineS, 1'b1);
            check($sformatf("vec%0d_busy_end", v), busyS, 1'b0);
            check($sformatf("vec%0d_pops", v), 32'(ackCnt - a0), 32'd1);
            check($sformatf("vec%0d_dones", v), 32'(doneCnt - d0), 32'd1);
        end

        // Back-to-back: second start bit on the tick that ends the first stop bit.
        a0 = ackCnt; d0 = doneCnt;
        startFrame(9'h0A5, 4'd8, 3'd0, 2'd0, "b2b");
        fifoIf.fifoData = 9'h03C;
        playBits(16'h014A, 9, 2, 0, "b2b_a");
        stepTick();
        check("b2b_done_a", doneS, 1'b1);
        check("b2b_gapless_start", lineS, 1'b0);
        check("b2b_pop_b", ackS, 1'b1);
        fifoIf.fifoEmpty = 1'b1;
        fifoIf.fifoData  = '0;
        playBits(16'h0078, 9, 2, 0, "b2b_b");
        stepTick();
        check("b2b_done_b", doneS, 1'b1);
        check("b2b_busy_end", busyS, 1'b0);
        check("b2b_pops", 32'(ackCnt - a0), 32'd2);
        check("b2b_dones", 32'(doneCnt - d0), 32'd2);

        // CTS gating, then a break requested mid-frame.
        a0 = ackCnt;
        ctsEnable = 1'b1; ctsN = 1'b1;
        dataBits = 4'd8; parityMode = 3'd0; stopBits = 2'd0;
        fifoIf.fifoData = 9'h055; fifoIf.fifoEmpty = 1'b0;
        repeat (3) stepTick();
        check("cts_busy", busyS, 1'b0);
        check("cts_line", lineS, 1'b1);
        check("cts_no_pop", 32'(ackCnt - a0), 32'd0);
        ctsN = 1'b0;
        @(posedge clock); #1;
        check("cts_go_busy", busy, 1'b1);
        stepTick();
        check("cts_start", lineS, 1'b0);
        check("cts_pop", ackS, 1'b1);
        fifoIf.fifoEmpty = 1'b1;
        ctsN = 1'b1;
        playBits(16'h00AA, 9, 2, 10, "brk");
        stepTick();
        check("brk_done", doneS, 1'b1);
        check("brk_line_t0", lineS, 1'b0);
        for (int k = 1; k < 10; k++) begin
            stepTick();
            check($sformatf("brk_line_t%0d", k), lineS, 1'b0);
        end
        breakReq = 1'b0;
        @(posedge clock); #1;
        check("mark_line", uartTxLine, 1'b1);
        check("mark_busy", busy, 1'b1);
        stepTick();
        check("mark_line_t1", lineS, 1'b1);
        check("mark_busy_t1", busyS, 1'b1);
        stepTick();
        check("mark_line_t2", lineS, 1'b1);
        check("mark_idle", busyS, 1'b0);
        check("brk_pops", 32'(ackCnt - a0), 32'd1);
        ctsEnable = 1'b0; ctsN = 1'b0;

        // Reset during data bit 3, released while a tick is present.
        a0 = ackCnt;
        startFrame(9'h055, 4'd8, 3'd0, 2'd0, "mrst");
        fifoIf.fifoData = 9'h03C;
        for (int j = 1; j <= 8; j++) stepTick();
        reset = 1'b0;
        #2;
        check("mrst_line_async", uartTxLine, 1'b1);
        check("mrst_busy_async", busy, 1'b0);
        baudTick = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        baudTick = 1'b0;
        check("mrst_no_load_pop", fifoIf.fifoReadAck, 1'b0);
        check("mrst_no_load_line", uartTxLine, 1'b1);
        check("mrst_pops_before", 32'(ackCnt - a0), 32'd1);
        stepTick();
        check("mrst_fresh_start", lineS, 1'b0);
        check("mrst_fresh_pop", ackS, 1'b1);
        fifoIf.fifoEmpty = 1'b1;
        playBits(16'h0078, 9, 2, 0, "mrst_b");
        stepTick();
        check("mrst_done", doneS, 1'b1);
        check("mrst_busy_end", busyS, 1'b0);
        check("mrst_pops", 32'(ackCnt - a0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
